// File: rtl/msi_directory_controller.sv
// MSI home-node directory controller: owns memory plus per-block directory state,
// snoops the other caches when required, then replies to the requester.
module msi_directory_controller #(
    parameter int NPROC  = 2,
    parameter int PID_W  = 1,
    parameter int ADDR_W = 4,
    parameter int DATA_W = 4
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              ReqValid,
    output logic              ReqReady,
    input  logic [PID_W-1:0]  ReqProc,
    input  logic [1:0]        ReqType,
    input  logic [ADDR_W-1:0] ReqAddress,
    input  logic [DATA_W-1:0] ReqData,
    output logic              SnpValid,
    output logic [1:0]        SnpType,
    output logic [NPROC-1:0]  SnpTarget,
    output logic [ADDR_W-1:0] SnpAddress,
    input  logic              SnpAckValid,
    input  logic [PID_W-1:0]  SnpAckProc,
    input  logic [DATA_W-1:0] SnpAckData,
    output logic              RespValid,
    output logic [PID_W-1:0]  RespProc,
    output logic [ADDR_W-1:0] RespAddress,
    output logic [DATA_W-1:0] RespData,
    output logic              Busy,
    input  logic [ADDR_W-1:0] DbgAddress,
    output logic [1:0]        DbgState,
    output logic [NPROC-1:0]  DbgSharers,
    output logic [DATA_W-1:0] DbgData
);
    localparam int DEPTH = 1 << ADDR_W;

    localparam logic [1:0] REQ_RD  = 2'b00;
    localparam logic [1:0] REQ_WR  = 2'b01;
    localparam logic [1:0] REQ_UPG = 2'b10;
    localparam logic [1:0] DIR_U   = 2'b00;
    localparam logic [1:0] DIR_S   = 2'b01;
    localparam logic [1:0] DIR_E   = 2'b10;
    localparam logic [1:0] SNP_INV  = 2'b01;
    localparam logic [1:0] SNP_FET  = 2'b10;
    localparam logic [1:0] SNP_FINV = 2'b11;

    typedef enum logic [2:0] {IDLE, LOOKUP, SNOOP, WAIT_ACK, REPLY} stateT;

    typedef struct packed {
        logic [PID_W-1:0]  proc;
        logic [1:0]        kind;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } reqT;

    stateT state, nextState;
    reqT   req;

    logic [1:0]        dirState [DEPTH];
    logic [NPROC-1:0]  dirMask  [DEPTH];
    logic [DATA_W-1:0] mem      [DEPTH];

    logic [NPROC-1:0]  pending;
    logic [DATA_W-1:0] ackData;

    logic [1:0]        curSt;
    logic [NPROC-1:0]  curMask, reqBit, ackBit;
    logic [DATA_W-1:0] curData;
    logic              isOwner, ackHit, lastAck;

    logic              planSnoop, planWbWrite, planFromAck;
    logic [1:0]        planSnpType, planSt;
    logic [NPROC-1:0]  planSnpTarget, planMask;
    logic [DATA_W-1:0] planRespData;

    assign curSt   = dirState[req.addr];
    assign curMask = dirMask[req.addr];
    assign curData = mem[req.addr];
    assign reqBit  = NPROC'(1) << req.proc;
    assign isOwner = (curSt == DIR_E) && (curMask == reqBit);

    // An ack from a cache outside NPROC shifts to zero and never hits.
    assign ackBit  = NPROC'(1) << SnpAckProc;
    assign ackHit  = SnpAckValid && (|(pending & ackBit));
    assign lastAck = ((pending & ~ackBit) == '0);

    assign ReqReady   = (state == IDLE) && !Reset;
    assign Busy       = (state != IDLE);
    assign DbgState   = dirState[DbgAddress];
    assign DbgSharers = dirMask[DbgAddress];
    assign DbgData    = mem[DbgAddress];

    // Action plan for the latched request; arrays only change in REPLY, so the
    // plan stays valid from LOOKUP through REPLY.
    always_comb begin
        planSnoop     = 1'b0;
        planSnpType   = SNP_INV;
        planSnpTarget = '0;
        planSt        = curSt;
        planMask      = curMask;
        planWbWrite   = 1'b0;
        planFromAck   = 1'b0;
        planRespData  = curData;
        case (req.kind)
            REQ_RD: begin
                if (curSt == DIR_E && !isOwner) begin
                    planSnoop     = 1'b1;
                    planSnpType   = SNP_FET;
                    planSnpTarget = curMask;
                    planSt        = DIR_S;
                    planMask      = curMask | reqBit;
                    planFromAck   = 1'b1;
                end else if (curSt == DIR_S) begin
                    planSt   = DIR_S;
                    planMask = curMask | reqBit;
                end else begin
                    planSt   = DIR_S;
                    planMask = reqBit;
                end
            end
            REQ_WR, REQ_UPG: begin
                if (curSt == DIR_E && !isOwner) begin
                    planSnoop     = 1'b1;
                    planSnpType   = SNP_FINV;
                    planSnpTarget = curMask;
                    planFromAck   = 1'b1;
                end else if (curSt == DIR_S && (|(curMask & ~reqBit))) begin
                    planSnoop     = 1'b1;
                    planSnpType   = SNP_INV;
                    planSnpTarget = curMask & ~reqBit;
                end
                planSt   = DIR_E;
                planMask = reqBit;
            end
            default: begin
                // Stale writebacks leave memory and directory untouched.
                if (isOwner) begin
                    planWbWrite  = 1'b1;
                    planSt       = DIR_U;
                    planMask     = '0;
                    planRespData = req.data;
                end
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) state <= IDLE;
        else       state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:     if (ReqValid && ReqReady) nextState = LOOKUP;
            LOOKUP:   nextState = planSnoop ? SNOOP : REPLY;
            SNOOP:    nextState = WAIT_ACK;
            WAIT_ACK: if (ackHit && lastAck) nextState = REPLY;
            REPLY:    nextState = IDLE;
            default:  nextState = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            SnpValid    <= 1'b0;
            SnpType     <= '0;
            SnpTarget   <= '0;
            SnpAddress  <= '0;
            RespValid   <= 1'b0;
            RespProc    <= '0;
            RespAddress <= '0;
            RespData    <= '0;
            pending     <= '0;
            ackData     <= '0;
            req         <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                dirState[i] <= DIR_U;
                dirMask[i]  <= '0;
                mem[i]      <= DATA_W'(i);
            end
        end else begin
            SnpValid  <= 1'b0;
            RespValid <= 1'b0;
            case (state)
                IDLE: begin
                    if (ReqValid && ReqReady)
                        req <= '{proc: ReqProc, kind: ReqType, addr: ReqAddress, data: ReqData};
                end
                LOOKUP: begin
                    if (planSnoop) begin
                        SnpValid   <= 1'b1;
                        SnpType    <= planSnpType;
                        SnpTarget  <= planSnpTarget;
                        SnpAddress <= req.addr;
                        pending    <= planSnpTarget;
                    end else begin
                        RespValid   <= 1'b1;
                        RespProc    <= req.proc;
                        RespAddress <= req.addr;
                        RespData    <= planRespData;
                    end
                end
                WAIT_ACK: begin
                    if (ackHit) begin
                        pending <= pending & ~ackBit;
                        if (planFromAck) ackData <= SnpAckData;
                        if (lastAck) begin
                            RespValid   <= 1'b1;
                            RespProc    <= req.proc;
                            RespAddress <= req.addr;
                            RespData    <= planFromAck ? SnpAckData : curData;
                        end
                    end
                end
                REPLY: begin
                    dirState[req.addr] <= planSt;
                    dirMask[req.addr]  <= planMask;
                    if (planWbWrite)      mem[req.addr] <= req.data;
                    else if (planFromAck) mem[req.addr] <= ackData;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_msi_directory_controller.sv
// Directed bench for msi_directory_controller: a transaction table with expected
// snoops, replies and directory contents, plus reset and stray-ack sequences.
module tb_msi_directory_controller;
    localparam int NPROC = 2, PID_W = 1, ADDR_W = 4, DATA_W = 4;

    logic Clock = 1'b0, Reset = 1'b1;
    logic ReqValid = 1'b0, ReqReady;
    logic [PID_W-1:0] ReqProc = '0;
    logic [1:0] ReqType = '0;
    logic [ADDR_W-1:0] ReqAddress = '0;
    logic [DATA_W-1:0] ReqData = '0;
    logic SnpValid;
    logic [1:0] SnpType;
    logic [NPROC-1:0] SnpTarget;
    logic [ADDR_W-1:0] SnpAddress;
    logic SnpAckValid = 1'b0;
    logic [PID_W-1:0] SnpAckProc = '0;
    logic [DATA_W-1:0] SnpAckData = '0;
    logic RespValid;
    logic [PID_W-1:0] RespProc;
    logic [ADDR_W-1:0] RespAddress;
    logic [DATA_W-1:0] RespData;
    logic Busy;
    logic [ADDR_W-1:0] DbgAddress = '0;
    logic [1:0] DbgState;
    logic [NPROC-1:0] DbgSharers;
    logic [DATA_W-1:0] DbgData;

    int total = 0, bad = 0;

    msi_directory_controller #(.NPROC(NPROC), .PID_W(PID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .Clock(Clock), .Reset(Reset), .ReqValid(ReqValid), .ReqReady(ReqReady),
        .ReqProc(ReqProc), .ReqType(ReqType), .ReqAddress(ReqAddress), .ReqData(ReqData),
        .SnpValid(SnpValid), .SnpType(SnpType), .SnpTarget(SnpTarget), .SnpAddress(SnpAddress),
        .SnpAckValid(SnpAckValid), .SnpAckProc(SnpAckProc), .SnpAckData(SnpAckData),
        .RespValid(RespValid), .RespProc(RespProc), .RespAddress(RespAddress), .RespData(RespData),
        .Busy(Busy), .DbgAddress(DbgAddress), .DbgState(DbgState), .DbgSharers(DbgSharers),
        .DbgData(DbgData)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        int proc; int kind; int addr; int data;
        int expSnp; int snpType; int snpTarget; int ackData;
        int respData; int dbgState; int dbgMask; int dbgData;
    } txnT;

    txnT vecs[20];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Called 1 time unit after a posedge; returns 1 time unit into cycle T+1.
    task automatic issue(input string tag, input int proc, input int kind, input int addr, input int data);
        int n = 0;
        ReqValid = 1'b1; ReqProc = PID_W'(proc); ReqType = 2'(kind);
        ReqAddress = ADDR_W'(addr); ReqData = DATA_W'(data);
        while (!ReqReady && n < 50) begin
            @(posedge Clock); #1; n++;
        end
        if (!ReqReady) check({tag, "_accept_timeout"}, 0, 1);
        @(posedge Clock); #1;
        ReqValid = 1'b0;
    endtask

    task automatic checkDbg(input string tag, input int addr, input int st, input int msk, input int dat);
        DbgAddress = ADDR_W'(addr);
        #1;
        check({tag, "_dbg_state"}, DbgState, st);
        check({tag, "_dbg_mask"}, DbgSharers, msk);
        check({tag, "_dbg_data"}, DbgData, dat);
    endtask

    task automatic runTxn(input string tag, input txnT v);
        issue(tag, v.proc, v.kind, v.addr, v.data);
        @(negedge Clock);
        check({tag, "_lookup_resp"}, RespValid, 0);
        check({tag, "_lookup_snp"}, SnpValid, 0);
        check({tag, "_busy"}, Busy, 1);
        @(negedge Clock);
        if (v.expSnp != 0) begin
            check({tag, "_snp_valid"}, SnpValid, 1);
            check({tag, "_snp_type"}, SnpType, v.snpType);
            check({tag, "_snp_target"}, SnpTarget, v.snpTarget);
            check({tag, "_snp_addr"}, SnpAddress, v.addr);
            check({tag, "_early_resp"}, RespValid, 0);
            @(negedge Clock);
            check({tag, "_snp_pulse"}, SnpValid, 0);
            check({tag, "_snp_hold"}, SnpType, v.snpType);
            @(posedge Clock); #1;
            for (int i = 0; i < NPROC; i++) begin
                if (v.snpTarget[i]) begin
                    SnpAckValid = 1'b1; SnpAckProc = PID_W'(i); SnpAckData = DATA_W'(v.ackData);
                    @(posedge Clock); #1;
                end
            end
            SnpAckValid = 1'b0;
            @(negedge Clock);
        end else begin
            check({tag, "_no_snp"}, SnpValid, 0);
        end
        check({tag, "_resp_valid"}, RespValid, 1);
        check({tag, "_resp_proc"}, RespProc, v.proc);
        check({tag, "_resp_addr"}, RespAddress, v.addr);
        check({tag, "_resp_data"}, RespData, v.respData);
        @(negedge Clock);
        check({tag, "_resp_pulse"}, RespValid, 0);
        check({tag, "_ready_back"}, ReqReady, 1);
        checkDbg(tag, v.addr, v.dbgState, v.dbgMask, v.dbgData);
        @(posedge Clock); #1;
    endtask

    initial begin
        // proc kind addr data | snp type target ackData | resp dbgState dbgMask dbgData
        vecs[0]  = '{0, 0, 3, 0,  0, 0, 0, 0,   3, 1, 1, 3};
        vecs[1]  = '{1, 1, 3, 0,  1, 1, 1, 0,   3, 2, 2, 3};
        vecs[2]  = '{0, 0, 3, 0,  1, 2, 2, 9,   9, 1, 3, 9};
        vecs[3]  = '{1, 1, 1, 0,  0, 0, 0, 0,   1, 2, 2, 1};
        vecs[4]  = '{1, 3, 1, 6,  0, 0, 0, 0,   6, 0, 0, 6};
        vecs[5]  = '{0, 3, 1, 2,  0, 0, 0, 0,   6, 0, 0, 6};
        vecs[6]  = '{0, 2, 3, 0,  1, 1, 2, 4,   9, 2, 1, 9};
        vecs[7]  = '{1, 2, 3, 0,  1, 3, 1, 5,   5, 2, 2, 5};
        vecs[8]  = '{1, 0, 3, 0,  0, 0, 0, 0,   5, 1, 2, 5};
        vecs[9]  = '{1, 1, 3, 0,  0, 0, 0, 0,   5, 2, 2, 5};
        vecs[10] = '{0, 1, 2, 0,  0, 0, 0, 0,   2, 2, 1, 2};
        vecs[11] = '{0, 1, 2, 0,  0, 0, 0, 0,   2, 2, 1, 2};
        vecs[12] = '{1, 3, 2, 7,  0, 0, 0, 0,   2, 2, 1, 2};
        vecs[13] = '{0, 0, 5, 0,  0, 0, 0, 0,   5, 1, 1, 5};
        vecs[14] = '{1, 0, 5, 0,  0, 0, 0, 0,   5, 1, 3, 5};
        vecs[15] = '{0, 2, 5, 0,  1, 1, 2, 0,   5, 2, 1, 5};
        vecs[16] = '{1, 2, 2, 0,  1, 3, 1, 12, 12, 2, 2, 12};
        vecs[17] = '{0, 3, 2, 3,  0, 0, 0, 0,  12, 2, 2, 12};
        vecs[18] = '{0, 0, 15, 0, 0, 0, 0, 0,  15, 1, 1, 15};
        vecs[19] = '{1, 1, 15, 0, 1, 1, 1, 0,  15, 2, 2, 15};

        // Reset state
        @(posedge Clock); #1;
        @(negedge Clock);
        check("rst_ready", ReqReady, 0);
        check("rst_snp_valid", SnpValid, 0);
        check("rst_resp_valid", RespValid, 0);
        check("rst_resp_data", RespData, 0);
        check("rst_busy", Busy, 0);
        checkDbg("rst", 3, 0, 0, 3);
        @(posedge Clock); #1;
        Reset = 1'b0;
        #1 check("post_rst_ready", ReqReady, 1);

        for (int i = 0; i < 20; i++) runTxn($sformatf("v%0d", i), vecs[i]);

        // Stray and duplicate acks must not finish the snoop.
        runTxn("b_rd0", '{0, 0, 8, 0, 0, 0, 0, 0, 8, 1, 1, 8});
        runTxn("b_rd1", '{1, 0, 8, 0, 0, 0, 0, 0, 8, 1, 3, 8});
        issue("b_wm", 0, 1, 8, 0);
        @(negedge Clock);
        @(negedge Clock);
        check("b_snp_valid", SnpValid, 1);
        check("b_snp_type", SnpType, 1);
        check("b_snp_target", SnpTarget, 2);
        @(posedge Clock); #1;
        @(posedge Clock); #1;
        SnpAckValid = 1'b1; SnpAckProc = 1'b0; SnpAckData = 4'hA;
        @(posedge Clock); #1;
        @(negedge Clock);
        check("b_stray1_resp", RespValid, 0);
        check("b_stray1_ready", ReqReady, 0);
        @(negedge Clock);
        check("b_stray2_resp", RespValid, 0);
        check("b_stray2_ready", ReqReady, 0);
        @(posedge Clock); #1;
        SnpAckProc = 1'b1;
        @(negedge Clock);
        check("b_lastack_resp", RespValid, 0);
        check("b_lastack_busy", Busy, 1);
        @(posedge Clock); #1;
        SnpAckValid = 1'b0;
        @(negedge Clock);
        check("b_resp_valid", RespValid, 1);
        check("b_resp_proc", RespProc, 0);
        check("b_resp_data", RespData, 8);
        check("b_ready_low", ReqReady, 0);
        @(negedge Clock);
        check("b_ready_back", ReqReady, 1);
        checkDbg("b", 8, 2, 1, 8);
        @(posedge Clock); #1;

        // Reset in the middle of WAIT_ACK, followed by a late ack.
        runTxn("r_rd", '{0, 0, 7, 0, 0, 0, 0, 0, 7, 1, 1, 7});
        issue("r_wm", 1, 1, 7, 0);
        @(negedge Clock);
        @(negedge Clock);
        check("r_snp_valid", SnpValid, 1);
        @(posedge Clock); #1;
        Reset = 1'b1;
        @(negedge Clock);
        check("r_ready_in_rst", ReqReady, 0);
        @(posedge Clock); #1;
        @(negedge Clock);
        check("r_snp_type", SnpType, 0);
        check("r_snp_target", SnpTarget, 0);
        check("r_snp_addr", SnpAddress, 0);
        check("r_resp_proc", RespProc, 0);
        check("r_resp_addr", RespAddress, 0);
        check("r_resp_data", RespData, 0);
        check("r_busy", Busy, 0);
        @(posedge Clock); #1;
        Reset = 1'b0;
        SnpAckValid = 1'b1; SnpAckProc = 1'b0; SnpAckData = 4'h9;
        @(posedge Clock); #1;
        SnpAckValid = 1'b0;
        @(negedge Clock);
        check("r_late_resp", RespValid, 0);
        check("r_late_busy", Busy, 0);
        check("r_late_ready", ReqReady, 1);
        checkDbg("r_wiped3", 3, 0, 0, 3);
        checkDbg("r_wiped7", 7, 0, 0, 7);
        @(posedge Clock); #1;
        runTxn("r_after", '{0, 0, 7, 0, 0, 0, 0, 0, 7, 1, 1, 7});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end
endmodule
